// File: rtl/acc_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_sched_pkg                                                              |
// | Shared state encoding and counter sizing for the accumulation scheduler.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package acc_sched_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ARMED = ARMED,
        ST_RUN   = RUN
    } state_t;

    localparam int DEF_CHANNEL_ADDR = 7;
    localparam int DEF_LEN_W        = 32;
    localparam int CNT_W            = DEF_LEN_W + DEF_CHANNEL_ADDR;

    // Sample counter must hold len << channel_addr without truncation.
    function automatic int cnt_width(input int len_w, input int channel_addr);
        return len_w + channel_addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_frame_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_frame_counter                                                          |
// | ce-gated sample counter with wide terminal compare; flags the last sample  |
// | of a frame. Optional mid_frame output under ACC_SCHEDULER_RESYNC_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acc_frame_counter
    import acc_sched_pkg::*;
#(
    parameter int CHANNEL_ADDR = DEF_CHANNEL_ADDR,
    parameter int LEN_W        = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             ce,
    input  logic [LEN_W-1:0] len,
`ifdef ACC_SCHEDULER_RESYNC_EN
    output logic             mid_frame,
`endif
    output logic             frame_end
);

    localparam int c_cnt_w = cnt_width(LEN_W, CHANNEL_ADDR);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_base;
    logic [c_cnt_w-1:0] w_last;
    logic               w_active;

    // A start cycle counts its own sample as index 0 of the new frame.
    assign w_base    = start ? '0 : r_cnt;
    assign w_last    = (c_cnt_w'(len) << CHANNEL_ADDR) - c_cnt_w'(1);
    assign w_active  = start | run;
    assign frame_end = w_active & ce & (w_base == w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_active) begin
            if (frame_end) begin
                r_cnt <= '0;
            end else if (ce) begin
                r_cnt <= w_base + c_cnt_w'(1);
            end else begin
                r_cnt <= w_base;
            end
        end
    end

`ifdef ACC_SCHEDULER_RESYNC_EN
    assign mid_frame = (r_cnt != '0);
`endif

endmodule
`default_nettype wire

// File: rtl/acc_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_scheduler                                                              |
// | Double-buffered spectrometer accumulation sequencer: arm/sync start, bank  |
// | swap, readout handshake, overflow flag. Optional: ACC_SCHEDULER_RESYNC_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acc_scheduler
    import acc_sched_pkg::*;
#(
    parameter int CHANNEL_ADDR = DEF_CHANNEL_ADDR,
    parameter int LEN_W        = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             sync_in,
    input  logic             arm,
    input  logic             stop,
    input  logic [LEN_W-1:0] acc_len,
    output logic             new_acc,
    output logic             bank_sel,
    output logic             rd_req,
    input  logic             rd_ack,
    output logic [LEN_W-1:0] acc_count,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             busy
`ifdef ACC_SCHEDULER_RESYNC_EN
    ,
    output logic             resync_seen
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len_q;
    logic               r_bank_sel;
    logic               r_rd_req;
    logic [LEN_W-1:0]   r_acc_count;
    logic               r_ovf;
    logic               r_stop_pend;
    logic               r_fe_pulse;

    logic               w_start;
    logic               w_run;
    logic               w_resync;
    logic               w_arm_accept;
    logic               w_frame_end;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_cnt_len;

    // A zero length is treated as one spectrum per accumulation.
    assign w_len     = (acc_len == '0) ? LEN_W'(1) : acc_len;
    assign w_start   = (r_state == ST_ARMED) & sync_in & ~stop;
    assign w_run     = (r_state == ST_RUN);
    assign w_cnt_len = w_start ? w_len : r_len_q;

`ifdef ACC_SCHEDULER_RESYNC_EN
    logic w_mid_frame;
    logic r_resync_seen;

    assign w_resync = w_run & sync_in & w_mid_frame;

    acc_frame_counter #(
        .CHANNEL_ADDR (CHANNEL_ADDR),
        .LEN_W        (LEN_W)
    ) u_frame_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start | w_resync),
        .run       (w_run),
        .ce        (ce),
        .len       (w_cnt_len),
        .mid_frame (w_mid_frame),
        .frame_end (w_frame_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resync_seen <= 1'b0;
        end else if (w_resync) begin
            r_resync_seen <= 1'b1;
        end else if (ovf_clr) begin
            r_resync_seen <= 1'b0;
        end
    end

    assign resync_seen = r_resync_seen;
`else
    assign w_resync = 1'b0;

    acc_frame_counter #(
        .CHANNEL_ADDR (CHANNEL_ADDR),
        .LEN_W        (LEN_W)
    ) u_frame_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start),
        .run       (w_run),
        .ce        (ce),
        .len       (w_cnt_len),
        .frame_end (w_frame_end)
    );
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_arm_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_state_nxt  = ST_ARMED;
                    w_arm_accept = 1'b1;
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (sync_in) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A pending stop takes effect only once the frame has closed.
                if (w_frame_end && (stop || r_stop_pend)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len_q     <= '0;
            r_bank_sel  <= 1'b0;
            r_rd_req    <= 1'b0;
            r_acc_count <= '0;
            r_ovf       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_fe_pulse  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fe_pulse <= w_frame_end;

            if (w_start || w_frame_end) begin
                r_len_q <= w_len;
            end

            if (w_arm_accept) begin
                r_acc_count <= '0;
            end else if (w_frame_end) begin
                r_acc_count <= r_acc_count + LEN_W'(1);
            end

            if (w_frame_end || w_resync) begin
                r_bank_sel <= ~r_bank_sel;
            end

            // Frame-end set dominates a coincident ack.
            if (w_frame_end) begin
                r_rd_req <= 1'b1;
            end else if (rd_ack) begin
                r_rd_req <= 1'b0;
            end

            if (w_frame_end && r_rd_req && !rd_ack) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_state_nxt == ST_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (w_run && stop) begin
                r_stop_pend <= 1'b1;
            end
        end
    end

    assign new_acc   = w_start | r_fe_pulse | w_resync;
    assign bank_sel  = r_bank_sel;
    assign rd_req    = r_rd_req;
    assign acc_count = r_acc_count;
    assign ovf       = r_ovf;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/acc_scheduler.md
Name: acc_scheduler

Overview:
- Sequences a double-buffered spectrometer vector accumulator.
- Arms on software request, starts on the next sync_in, then counts valid samples (ce).
- Every acc_len spectra of 2**CHANNEL_ADDR channels it issues new_acc, swaps the accumulation bank and requests readout of the finished bank via a req/ack handshake.
- Sits between the PFB/FFT sync chain, the accumulator RAM banks and the readout/DMA engine.

Parameters:
- CHANNEL_ADDR, 7, log2 of channels per spectrum.
- LEN_W, 32, width of acc_len and acc_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  one valid channel sample this cycle
- sync_in  in  1  spectrum-start pulse from upstream
- arm  in  1  pulse: arm the scheduler (from IDLE only)
- stop  in  1  pulse: finish current frame, then go IDLE
- acc_len  in  LEN_W  spectra per accumulation; sampled at every frame start
- new_acc  out  1  one-cycle pulse: first sample of a new accumulation
- bank_sel  out  1  bank currently being accumulated
- rd_req  out  1  finished bank (= ~bank_sel) is ready for readout
- rd_ack  in  1  readout done; clears rd_req
- acc_count  out  LEN_W  completed accumulations since arm (wraps)
- ovf  out  1  sticky: a bank was swapped while rd_req was still pending
- ovf_clr  in  1  clears ovf
- busy  out  1  high in ARMED or RUN

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters 0.
- IDLE:
  - arm=1 -> ARMED.
  - sync_in is ignored.
- ARMED:
  - Waits for sync_in=1.
  - On that cycle: latch len_q = max(acc_len,1); sample counter = 0; go RUN.
  - new_acc is asserted on that same cycle.
  - stop=1 in ARMED -> IDLE.
- RUN:
  - Each ce=1 increments the sample counter.
  - Counter and terminal compare are LEN_W+CHANNEL_ADDR bits wide, so the terminal count len_q<<CHANNEL_ADDR is never truncated.
- Frame end (ce=1 while counter == terminal-1), registered, visible the next cycle:
  - new_acc pulses for 1 cycle.
  - bank_sel toggles.
  - acc_count increments.
  - rd_req set.
  - Counter cleared; len_q re-latched from acc_len.
- Overflow:
  - If rd_req is already 1 at a frame end, set ovf.
  - rd_req stays 1 and bank_sel still toggles (data loss accepted, flagged).
- rd_req / rd_ack:
  - rd_ack clears rd_req the next cycle.
  - rd_ack while rd_req=0 is ignored.
  - If frame end and rd_ack fall on the same cycle, the frame-end set wins (rd_req stays 1) and no ovf is raised.
- ovf:
  - Cleared only by ovf_clr or reset.
  - If set and clear coincide, set wins.
- stop in RUN:
  - Latched as pending.
  - At the next frame end, the normal frame-end actions occur, then state -> IDLE.
  - rd_req remains valid until acked.
- sync_in during RUN is ignored (without the optional feature).
- ce=0 stalls counting; no timeout.
- acc_len change mid-frame takes effect only at the next frame start.
- Latency:
  - new_acc coincides with the accepted sync_in cycle at start.
  - Otherwise new_acc comes 1 cycle after the terminal ce.

Optional Feature:
- Macro: ACC_SCHEDULER_RESYNC_EN.
- Defined: sync_in=1 in RUN with counter != 0 forces a restart:
  - counter cleared, new_acc pulses, bank_sel toggles.
  - The partial frame is discarded: no rd_req, acc_count unchanged.
  - A sticky resync_seen output port is added; cleared by ovf_clr.
- Undefined: sync_in in RUN ignored; no resync_seen port.

Decomposition:
- Package acc_sched_pkg:
  - state encoding localparams (IDLE=2'd0, ARMED=2'd1, RUN=2'd2).
  - CNT_W = LEN_W+CHANNEL_ADDR.
- One sub-module, acc_frame_counter: ce-gated counter with clear and wide terminal compare, returning the frame-end pulse.
- The FSM, bank/handshake and flag logic stay in the top.

Test Plan:
1. CHANNEL_ADDR=3, acc_len=2, ce always 1, arm then sync_in at t0:
   - new_acc at t0, then every 16 cycles.
   - bank_sel toggles 0->1->0; acc_count 1,2.
2. acc_len=0:
   - Behaves as acc_len=1: new_acc period 8.
3. Same setup as 1, rd_ack never given:
   - After the 2nd frame end, ovf=1 and rd_req stays 1.
   - ovf_clr clears ovf; ovf_clr and a set in the same cycle leaves ovf=1.
4. ce toggling 50%:
   - Period doubles to 32 cycles.
   - acc_len changed 2->4 mid-frame: current frame 16 samples, next 32.
5. stop mid-frame:
   - Frame completes, rd_req=1, busy drops next cycle.
   - Later sync_in produces no new_acc until re-armed.
6. rst_n asserted mid-RUN, asynchronously between clock edges:
   - All outputs 0 immediately.
   - After release, sync_in without arm does nothing.
   - With ACC_SCHEDULER_RESYNC_EN: sync mid-frame -> new_acc, acc_count unchanged, resync_seen=1.
